noc_mm_tile_scheduler: RTL and testbench
========================================

Name: noc_mm_tile_scheduler

Overview:
- Sequences one full matrix multiply D = A x B, with A of size M1xM2 and B of size M2xM3.
- Splits D into N1xN2 output tiles and issues one command per tile to the NoC systolic engine: DDR addresses plus tile extents.
- Tracks tile completions under an outstanding-command credit limit, and reports overall done/error.
- Sits between the host control registers and the NoC matrix-multiply datapath.

Parameters:
- D_W, 8: input element width in bits; byte size = D_W/8.
- D_W_ACC, 32: output element width in bits; byte size = D_W_ACC/8.
- N1, 2: systolic rows, i.e. tile height.
- N2, 2: systolic columns, i.e. tile width.
- MATRIXSIZE_W, 24: width of each dimension field.
- MAX_OUT, 2: maximum outstanding tile commands (1..15).

Ports:
- clk_pl  in  1  single clock for all logic.
- rst_pl  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- M1, M2, M3  in  MATRIXSIZE_W each  dimensions; latched on accepted start.
- addr_matrix_a, addr_matrix_b, addr_matrix_d  in  64 each  base addresses; latched on accepted start.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse at completion.
- error  out  1  sticky; cleared on the next accepted start.
- cmd_valid  out  1  tile command valid.
- cmd_ready  in  1  engine accepts the command.
- cmd_a_addr, cmd_b_addr, cmd_d_addr  out  64 each  tile base addresses.
- cmd_rows  out  MATRIXSIZE_W  tile height, 1..N1.
- cmd_cols  out  MATRIXSIZE_W  tile width, 1..N2.
- cmd_k  out  MATRIXSIZE_W  equals M2.
- cmd_last  out  1  marks the final tile.
- tile_done  in  1  one-cycle completion pulse from the engine.
- tile_err  in  1  qualifies tile_done as failed.

Behaviour:
- Reset values: busy, done, error, cmd_valid and cmd_last = 0; all address and extent outputs = 0; outstanding count = 0; state = IDLE.
- Reset applies mid-operation with the same result. Commands in flight are discarded and later tile_done pulses are ignored while in IDLE.
- States: IDLE, CHECK, ISSUE, DRAIN, FIN.
- IDLE -> CHECK on start. This cycle latches inputs, clears error and sets busy. start is ignored in every other state.
- CHECK, one cycle:
  - If any of M1, M2, M3 is 0: set error and go to FIN.
  - Otherwise: tile row index i = 0, tile column index j = 0, go to ISSUE.
- Tile order is row-major over tile indices: j increments first, then i. Tile counts are ceil(M1/N1) x ceil(M3/N2).
- Tile extents:
  - cmd_rows = min(N1, M1 - i*N1).
  - cmd_cols = min(N2, M3 - j*N2).
- Tile addresses, with EA = D_W/8 and ED = D_W_ACC/8:
  - a_addr = base_a + i*N1*M2*EA.
  - b_addr = base_b + j*N2*EA; B is row-major with row stride M3.
  - d_addr = base_d + (i*N1*M3 + j*N2)*ED.
  - All three are computed by running accumulators (add on each advance). No multipliers in the issue path.
  - Addresses wrap modulo 2^64.
- ISSUE:
  - cmd_valid is asserted only while outstanding < MAX_OUT.
  - The command fields are held stable while cmd_valid=1 and cmd_ready=0.
  - On handshake (valid & ready): outstanding += 1 and the tile advances. The next command may be presented in the cycle after the handshake, giving a throughput of 1 tile/cycle when credits allow.
  - After the handshake of the cmd_last tile, go to DRAIN.
- Completions, in any busy state:
  - tile_done decrements outstanding.
  - A handshake and a tile_done in the same cycle leave the count unchanged.
  - tile_done with outstanding = 0 is spurious: it sets error and the count stays at 0.
- tile_done & tile_err:
  - Sets error.
  - Issuing stops immediately: cmd_valid drops the next cycle unless a handshake occurs in the same cycle.
  - State goes to DRAIN.
- DRAIN -> FIN when outstanding = 0.
- FIN: done = 1 for exactly one cycle; busy = 0 in the same cycle; then IDLE.
- Latency for M1=M2=M3=N1=N2=1 with cmd_ready tied high and tile_done returned one cycle after the handshake: done pulses 5 cycles after start.

Optional Feature:
- Macro: NOC_MM_SCHED_PERF_EN.
- Defined: adds output perf_cycles[31:0] and output perf_stall[31:0].
  - Both clear on an accepted start.
  - perf_cycles increments every busy cycle and saturates at 0xFFFFFFFF.
  - perf_stall increments on cycles in ISSUE with cmd_valid=1 and cmd_ready=0, or with outstanding = MAX_OUT.
  - Both hold their values after done.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Base case: M1=M2=M3=4, N1=N2=2, bases 0x1000_0000 / 0x2000_0000 / 0x3000_0000, cmd_ready=1, engine returns tile_done 3 cycles after each handshake.
  - Exactly 4 commands: (0,0), (0,1), (1,0), (1,1).
  - Tile (1,1): a=0x1000_0008, b=0x2000_0002, d=0x3000_0028, rows=cols=2, k=4.
  - cmd_last only on the 4th command; a single done pulse; error=0.
- Edge tiles: M1=3, M2=4, M3=5 → 6 commands; last tile rows=1, cols=1, d=base_d+(2*5+4)*4.
- Zero dimension: M2=0 → no cmd_valid; done and error both asserted 2 cycles after start.
- Backpressure and credits: MAX_OUT=2, cmd_ready held low for 5 cycles, tile_done withheld.
  - Command fields stay stable while ready is low.
  - At most 2 handshakes occur before the first tile_done.
- Tile error: tile_err on the 2nd tile_done of a 4-tile job.
  - No further handshakes.
  - done follows once outstanding drains to 0; error stays 1 until the next start.
- Reset and restart: rst_pl asserted mid-ISSUE.
  - All outputs return to reset values the next cycle.
  - A subsequent start runs the base case correctly.

Source files
------------

// File: rtl/noc_mm_tile_scheduler.sv
// Tile scheduler for D = A x B on the NoC systolic engine: walks N1xN2 output tiles row-major,
// issues one command per tile under an outstanding-credit limit. NOC_MM_SCHED_PERF_EN adds counters.
module noc_mm_tile_scheduler #(
  parameter int unsigned D_W          = 8,
  parameter int unsigned D_W_ACC      = 32,
  parameter int unsigned N1           = 2,
  parameter int unsigned N2           = 2,
  parameter int unsigned MATRIXSIZE_W = 24,
  parameter int unsigned MAX_OUT      = 2
) (
  input  logic                    clk_pl,
  input  logic                    rst_pl,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] M1,
  input  logic [MATRIXSIZE_W-1:0] M2,
  input  logic [MATRIXSIZE_W-1:0] M3,
  input  logic [63:0]             addr_matrix_a,
  input  logic [63:0]             addr_matrix_b,
  input  logic [63:0]             addr_matrix_d,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [63:0]             cmd_a_addr,
  output logic [63:0]             cmd_b_addr,
  output logic [63:0]             cmd_d_addr,
  output logic [MATRIXSIZE_W-1:0] cmd_rows,
  output logic [MATRIXSIZE_W-1:0] cmd_cols,
  output logic [MATRIXSIZE_W-1:0] cmd_k,
  output logic                    cmd_last,
  input  logic                    tile_done,
  input  logic                    tile_err
`ifdef NOC_MM_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_cycles,
  output logic [31:0]             perf_stall
`endif
);

  typedef enum logic [2:0] {StIdle, StCheck, StIssue, StDrain, StFin} state_e;

  localparam logic [63:0] BColStep = 64'(N2 * D_W / 8);
  localparam logic [63:0] DColStep = 64'(N2 * D_W_ACC / 8);
  localparam logic [63:0] ARowUnit = 64'(N1 * D_W / 8);
  localparam logic [63:0] DRowUnit = 64'(N1 * D_W_ACC / 8);
  localparam logic [MATRIXSIZE_W-1:0] TileH = MATRIXSIZE_W'(N1);
  localparam logic [MATRIXSIZE_W-1:0] TileW = MATRIXSIZE_W'(N2);
  localparam logic [3:0] MaxOut = 4'(MAX_OUT);

  state_e state_q, state_d;
  logic [MATRIXSIZE_W-1:0] m1_q, m2_q, m3_q, rem_rows_q, rem_cols_q;
  logic [63:0] base_a_q, base_b_q, base_d_q;
  logic [63:0] a_addr_q, b_addr_q, d_addr_q, d_row_q, a_stride_q, d_stride_q;
  logic [3:0]  out_q, out_d;
  logic        error_q;

  logic last_row, last_col, hs, busy_st, cpl, spurious, cpl_ok, tile_fail, zero_dim;

  // rem_* hold the extent still uncovered from the current tile origin
  assign last_row  = rem_rows_q <= TileH;
  assign last_col  = rem_cols_q <= TileW;
  assign zero_dim  = (m1_q == '0) || (m2_q == '0) || (m3_q == '0);
  assign busy_st   = (state_q == StCheck) || (state_q == StIssue) || (state_q == StDrain);
  assign cmd_valid = (state_q == StIssue) && (out_q < MaxOut);
  assign hs        = cmd_valid && cmd_ready;
  assign cpl       = busy_st && tile_done;
  assign spurious  = cpl && (out_q == 4'd0);
  assign cpl_ok    = cpl && !spurious;
  assign tile_fail = cpl && tile_err;

  assign busy       = busy_st;
  assign done       = (state_q == StFin);
  assign error      = error_q;
  assign cmd_last   = (state_q == StIssue) && last_row && last_col;
  assign cmd_a_addr = a_addr_q;
  assign cmd_b_addr = b_addr_q;
  assign cmd_d_addr = d_addr_q;
  assign cmd_rows   = last_row ? rem_rows_q : TileH;
  assign cmd_cols   = last_col ? rem_cols_q : TileW;
  assign cmd_k      = m2_q;

  always_comb begin
    out_d = out_q;
    if (hs && !cpl_ok) out_d = out_q + 4'd1;
    else if (!hs && cpl_ok) out_d = out_q - 4'd1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCheck;
      StCheck: state_d = zero_dim ? StFin : StIssue;
      StIssue: if ((hs && cmd_last) || tile_fail) state_d = StDrain;
      StDrain: if (out_q == 4'd0) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_pl) begin
    if (rst_pl) begin
      state_q    <= StIdle;
      out_q      <= '0;
      error_q    <= 1'b0;
      m1_q       <= '0;
      m2_q       <= '0;
      m3_q       <= '0;
      rem_rows_q <= '0;
      rem_cols_q <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      base_d_q   <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      d_addr_q   <= '0;
      d_row_q    <= '0;
      a_stride_q <= '0;
      d_stride_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (state_q == StIdle && start) begin
        m1_q     <= M1;
        m2_q     <= M2;
        m3_q     <= M3;
        base_a_q <= addr_matrix_a;
        base_b_q <= addr_matrix_b;
        base_d_q <= addr_matrix_d;
        error_q  <= 1'b0;
        out_q    <= '0;
      end
      // Row strides are formed once here so the issue path only adds
      if (state_q == StCheck) begin
        if (zero_dim) error_q <= 1'b1;
        a_addr_q   <= base_a_q;
        b_addr_q   <= base_b_q;
        d_addr_q   <= base_d_q;
        d_row_q    <= base_d_q;
        rem_rows_q <= m1_q;
        rem_cols_q <= m3_q;
        a_stride_q <= 64'(m2_q) * ARowUnit;
        d_stride_q <= 64'(m3_q) * DRowUnit;
      end
      if (hs && !cmd_last) begin
        if (last_col) begin
          rem_cols_q <= m3_q;
          rem_rows_q <= rem_rows_q - TileH;
          a_addr_q   <= a_addr_q + a_stride_q;
          b_addr_q   <= base_b_q;
          d_row_q    <= d_row_q + d_stride_q;
          d_addr_q   <= d_row_q + d_stride_q;
        end else begin
          rem_cols_q <= rem_cols_q - TileW;
          b_addr_q   <= b_addr_q + BColStep;
          d_addr_q   <= d_addr_q + DColStep;
        end
      end
      if (spurious || tile_fail) error_q <= 1'b1;
    end
  end

`ifdef NOC_MM_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_stall_q;
  logic        stall;

  assign stall       = (state_q == StIssue) && ((cmd_valid && !cmd_ready) || (out_q == MaxOut));
  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;

  always_ff @(posedge clk_pl) begin
    if (rst_pl) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (state_q == StIdle && start) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (busy_st && perf_cycles_q != 32'hFFFF_FFFF) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (stall && perf_stall_q != 32'hFFFF_FFFF) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_mm_tile_scheduler.sv
// Scoreboard bench for noc_mm_tile_scheduler: a tile-list model fills expected queues at start,
// a negedge monitor checks handshakes, credits, field stability and done/error.
module tb_noc_mm_tile_scheduler;
  localparam int N1 = 2, N2 = 2, MAX_OUT = 2, EA = 1, ED = 4;

  logic        clk = 0, rst = 1, start = 0;
  logic [23:0] m1 = 0, m2 = 0, m3 = 0;
  logic [63:0] ba = 0, bb = 0, bd = 0;
  logic        busy, done, error, cmd_valid, cmd_last;
  logic        cmd_ready = 0, tile_done = 0, tile_err = 0;
  logic [63:0] cmd_a_addr, cmd_b_addr, cmd_d_addr;
  logic [23:0] cmd_rows, cmd_cols, cmd_k;

  noc_mm_tile_scheduler dut (
    .clk_pl(clk), .rst_pl(rst), .start(start), .M1(m1), .M2(m2), .M3(m3),
    .addr_matrix_a(ba), .addr_matrix_b(bb), .addr_matrix_d(bd),
    .busy(busy), .done(done), .error(error), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr), .cmd_d_addr(cmd_d_addr),
    .cmd_rows(cmd_rows), .cmd_cols(cmd_cols), .cmd_k(cmd_k), .cmd_last(cmd_last),
    .tile_done(tile_done), .tile_err(tile_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a, b, d;
    logic [23:0] rows, cols, k;
    logic        last;
  } cmd_t;

  cmd_t exp_cmd[$];
  bit   exp_err[$];
  int   due_q[$];
  int   tests = 0, fails = 0, cyc = 0;
  int   eng_lat = 1, fail_at = 0, done_cnt = 0, ready_pct = 100, ready_force_low = 0;
  int   tb_out = 0, hs_count = 0, fail_cyc = 0, t_start = 0, lat;
  bit   hold_done = 0, stop_seen = 0, prev_stall = 0;
  cmd_t saved;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Engine: returns tile_done eng_lat cycles after each handshake, optional tile_err
  initial forever begin
    @(posedge clk); #1;
    tile_done = 0;
    tile_err  = 0;
    if (!hold_done && due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      tile_done = 1;
      done_cnt++;
      tile_err = (done_cnt == fail_at);
    end
    if (ready_force_low > 0) begin
      cmd_ready = 0;
      ready_force_low--;
    end else cmd_ready = ($urandom_range(99) < ready_pct);
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (rst) prev_stall = 0;
    else begin
      int old_out;
      bit hs;
      hs = cmd_valid && cmd_ready;
      if (cmd_valid) chk("credit_limit", 64'(tb_out < MAX_OUT), 64'd1);
      if (prev_stall && cmd_valid) begin
        chk("hold_a", cmd_a_addr, saved.a);
        chk("hold_b", cmd_b_addr, saved.b);
        chk("hold_d", cmd_d_addr, saved.d);
        chk("hold_rows", 64'(cmd_rows), 64'(saved.rows));
        chk("hold_cols", 64'(cmd_cols), 64'(saved.cols));
      end
      if (hs) begin
        hs_count++;
        if (stop_seen) flag("handshake_after_tile_err");
        if (exp_cmd.size() == 0) flag("unexpected_cmd");
        else begin
          cmd_t e;
          e = exp_cmd.pop_front();
          chk("cmd_a_addr", cmd_a_addr, e.a);
          chk("cmd_b_addr", cmd_b_addr, e.b);
          chk("cmd_d_addr", cmd_d_addr, e.d);
          chk("cmd_rows", 64'(cmd_rows), 64'(e.rows));
          chk("cmd_cols", 64'(cmd_cols), 64'(e.cols));
          chk("cmd_k", 64'(cmd_k), 64'(e.k));
          chk("cmd_last", 64'(cmd_last), 64'(e.last));
        end
        due_q.push_back(cyc + eng_lat);
      end
      old_out = tb_out;
      if (tile_done && old_out > 0) tb_out--;
      if (hs) tb_out++;
      if (tile_done && tile_err) begin
        stop_seen = 1;
        fail_cyc  = cyc;
      end
      if (done) begin
        chk("busy_at_done", 64'(busy), 64'd0);
        if (exp_err.size() == 0) flag("extra_done");
        else begin
          bit ee;
          ee = exp_err.pop_front();
          chk("done_error", 64'(error), 64'(ee));
          if (ee) exp_cmd.delete();
          else chk("cmds_left_at_done", 64'(exp_cmd.size()), 64'd0);
        end
      end
      prev_stall = cmd_valid && !cmd_ready;
      saved.a = cmd_a_addr; saved.b = cmd_b_addr; saved.d = cmd_d_addr;
      saved.rows = cmd_rows; saved.cols = cmd_cols;
    end
  end

  task automatic start_job(input logic [23:0] a1, a2, a3, input logic [63:0] xa, xb, xd,
                           input int lat_i, input int fail_i, input int rpct);
    longint unsigned nti, ntj;
    bit zero;
    zero = (a1 == 0) || (a2 == 0) || (a3 == 0);
    nti = zero ? 0 : (longint'(a1) + N1 - 1) / N1;
    ntj = zero ? 0 : (longint'(a3) + N2 - 1) / N2;
    for (longint unsigned i = 0; i < nti; i++)
      for (longint unsigned j = 0; j < ntj; j++) begin
        cmd_t c;
        longint unsigned rr, cc;
        rr = longint'(a1) - i * N1;
        cc = longint'(a3) - j * N2;
        c.rows = 24'((rr < N1) ? rr : N1);
        c.cols = 24'((cc < N2) ? cc : N2);
        c.a = xa + i * N1 * longint'(a2) * EA;
        c.b = xb + j * N2 * EA;
        c.d = xd + (i * N1 * longint'(a3) + j * N2) * ED;
        c.k = a2;
        c.last = (i == nti - 1) && (j == ntj - 1);
        exp_cmd.push_back(c);
      end
    exp_err.push_back(zero || (fail_i > 0 && longint'(fail_i) <= nti * ntj));
    eng_lat = lat_i; fail_at = fail_i; done_cnt = 0; stop_seen = 0;
    ready_pct = rpct; hs_count = 0;
    @(posedge clk); #2;
    m1 = a1; m2 = a2; m3 = a3; ba = xa; bb = xb; bd = xd;
    start = 1;
    t_start = cyc;
    @(posedge clk); #2;
    start = 0;
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("error_cleared_on_start", 64'(error), 64'd0);
  endtask

  task automatic wait_done(output int l);
    bit got = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) flag("done_timeout");
    l = cyc - t_start;
    @(posedge clk); #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_cmd_last"}, 64'(cmd_last), 64'd0);
    chk({tag, "_a"}, cmd_a_addr, 64'd0);
    chk({tag, "_b"}, cmd_b_addr, 64'd0);
    chk({tag, "_d"}, cmd_d_addr, 64'd0);
    chk({tag, "_rows"}, 64'(cmd_rows), 64'd0);
    chk({tag, "_cols"}, 64'(cmd_cols), 64'd0);
    chk({tag, "_k"}, 64'(cmd_k), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #2;
    rst = 0;

    // Base case
    start_job(4, 4, 4, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 3, 0, 100);
    wait_done(lat);
    chk("base_cmd_count", 64'(hs_count), 64'd4);
    chk("base_error", 64'(error), 64'd0);

    // Single-tile latency
    start_job(1, 1, 1, 64'h40, 64'h80, 64'hC0, 1, 0, 100);
    wait_done(lat);
    chk("min_latency", 64'(lat), 64'd5);

    // Edge tiles
    start_job(3, 4, 5, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 2, 0, 100);
    wait_done(lat);
    chk("edge_cmd_count", 64'(hs_count), 64'd6);

    // Zero dimension
    start_job(4, 0, 4, 64'h1000, 64'h2000, 64'h3000, 1, 0, 100);
    wait_done(lat);
    chk("zero_dim_latency", 64'(lat), 64'd2);
    chk("zero_dim_cmds", 64'(hs_count), 64'd0);

    // Backpressure and withheld completions
    hold_done = 1;
    ready_force_low = 6;
    start_job(4, 4, 4, 64'h5000, 64'h6000, 64'h7000, 1, 0, 100);
    repeat (20) @(negedge clk);
    chk("credit_bound_handshakes", 64'(hs_count), 64'(MAX_OUT));
    hold_done = 0;
    wait_done(lat);
    chk("bp_cmd_count", 64'(hs_count), 64'd4);

    // Tile error on the 2nd completion
    start_job(4, 4, 4, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 3, 2, 100);
    wait_done(lat);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("error_sticky", 64'(error), 64'd1);
    end

    // Randomized jobs (also clears the sticky error on start)
    for (int n = 0; n < 8; n++) begin
      start_job(24'($urandom_range(1, 6)), 24'($urandom_range(1, 6)), 24'($urandom_range(1, 6)),
                {$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                $urandom_range(1, 4), ($urandom_range(3) == 0) ? $urandom_range(1, 4) : 0,
                $urandom_range(40, 100));
      wait_done(lat);
    end

    // Reset mid-issue, stray completion in idle, then restart
    start_job(4, 4, 4, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 3, 0, 100);
    for (int k = 0; k < 20 && hs_count < 1; k++) @(negedge clk);
    @(posedge clk); #2;
    rst = 1;
    exp_cmd.delete(); exp_err.delete(); due_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #2;
    rst = 0; tb_out = 0; stop_seen = 0;
    @(posedge clk); #2;
    tile_done = 1;
    @(negedge clk);
    @(negedge clk);
    chk("stray_done_idle_error", 64'(error), 64'd0);
    chk("stray_done_idle_busy", 64'(busy), 64'd0);
    start_job(4, 4, 4, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 3, 0, 100);
    wait_done(lat);
    chk("restart_cmd_count", 64'(hs_count), 64'd4);
    chk("restart_error", 64'(error), 64'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
